// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types and helpers for the registered priority encoder.
//   pe_state_t  - grant FSM state (PE_IDLE, PE_HOLD)
//   DROP_CNT_W  - width of the saturating drop counter
//   onehot()    - binary index to one-hot decode, shared with the 2-to-4 decoder
package prio_enc_pkg;

    typedef enum logic [0:0] {
        PE_IDLE = 1'b0,
        PE_HOLD = 1'b1
    } pe_state_t;

    localparam int DROP_CNT_W   = 8;

    // The decode is sized for the widest supported request vector (32 lines);
    // callers size-cast the result down to their own line count.
    localparam int ONEHOT_W     = 32;
    localparam int ONEHOT_IDX_W = 5;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: purely combinational N-to-W priority encoder.
// Bit 0 has the highest priority (lowest set index wins).
//   vec - input request vector (N bits)
//   idx - index of the lowest set bit, 0 when vec is all zero
//   any - 1 when at least one bit of vec is set
module prio_enc_comb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? W'(i) : idx;
        end
    end

    // Any-request flag.
    assign any = |vec;

endmodule

// File: rtl/prio_encoder.sv
// prio_encoder: registered priority encoder with sticky pending requests.
// Requests latch into a pending register; the lowest-index eligible line is
// presented on out_idx with out_valid and held stable until out_ready accepts
// it. The accepted line is cleared by one-hot decoding the granted index.
// Optional feature macro: PRIO_ENC_MASK_EN adds the mask input; masked lines
// still set and hold pend but are never selected.
// Ports:
//   clk       - clock, rising edge
//   reset_    - asynchronous active-low reset
//   req       - N request strobes, a one-cycle pulse sets the pending bit
//   mask      - N line blocks (only with PRIO_ENC_MASK_EN)
//   out_ready - consumer accepts out_idx when out_valid & out_ready
//   out_valid - out_idx holds a granted request (registered)
//   out_idx   - binary index of the granted request (registered)
//   pend      - pending register, for status/debug
//   drop_cnt  - saturating count of cycles in which a request coalesced
module prio_encoder
    import prio_enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [N-1:0]          req,
`ifdef PRIO_ENC_MASK_EN
    input  logic [N-1:0]          mask,
`endif
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_idx,
    output logic [N-1:0]          pend,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    pe_state_t             state_r;
    pe_state_t             state_n;
    logic                  valid_r;
    logic                  valid_n;
    logic [W-1:0]          idx_r;
    logic [W-1:0]          idx_n;
    logic [N-1:0]          pend_r;
    logic [DROP_CNT_W-1:0] drop_r;
    logic [DROP_CNT_W-1:0] drop_n;

    logic                  hs_s;
    logic [N-1:0]          clr_s;
    logic [N-1:0]          pend_n_s;
    logic [N-1:0]          elig_s;
    logic [W-1:0]          enc_s;
    logic                  any_s;
    logic                  drop_hit_s;

    assign hs_s  = valid_r & out_ready;
    assign clr_s = hs_s ? N'(onehot(ONEHOT_IDX_W'(idx_r))) : {N{1'b0}};

    // Set wins over clear: a request arriving on the line being accepted keeps it pending.
    assign pend_n_s = (pend_r & ~clr_s) | req;

`ifdef PRIO_ENC_MASK_EN
    assign elig_s = pend_n_s & ~mask;
`else
    assign elig_s = pend_n_s;
`endif

    // A request landing on a line that is already pending and not being cleared is lost.
    assign drop_hit_s = |(req & pend_r & ~clr_s);

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_enc (
        .vec (elig_s),
        .idx (enc_s),
        .any (any_s)
    );

    // Grant FSM: load a new index from IDLE or on a handshake, otherwise hold.
    always_comb begin
        state_n = state_r;
        valid_n = valid_r;
        idx_n   = idx_r;
        case (state_r)
            PE_IDLE: begin
                if (any_s) begin
                    state_n = PE_HOLD;
                    valid_n = 1'b1;
                    idx_n   = enc_s;
                end else begin
                    state_n = PE_IDLE;
                    valid_n = 1'b0;
                end
            end
            PE_HOLD: begin
                if (hs_s) begin
                    if (any_s) begin
                        state_n = PE_HOLD;
                        valid_n = 1'b1;
                        idx_n   = enc_s;
                    end else begin
                        state_n = PE_IDLE;
                        valid_n = 1'b0;
                    end
                end else begin
                    // No pre-emption: the held index stays put until accepted.
                    state_n = PE_HOLD;
                    valid_n = 1'b1;
                end
            end
            default: begin
                state_n = PE_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    // Saturating drop counter next value.
    always_comb begin
        drop_n = drop_r;
        if (drop_hit_s && (drop_r != {DROP_CNT_W{1'b1}})) begin
            drop_n = drop_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            drop_n = drop_r;
        end
    end

    // State, grant, pending and drop registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r <= PE_IDLE;
            valid_r <= 1'b0;
            idx_r   <= {W{1'b0}};
            pend_r  <= {N{1'b0}};
            drop_r  <= {DROP_CNT_W{1'b0}};
        end else begin
            state_r <= state_n;
            valid_r <= valid_n;
            idx_r   <= idx_n;
            pend_r  <= pend_n_s;
            drop_r  <= drop_n;
        end
    end

    assign out_valid = valid_r;
    assign out_idx   = idx_r;
    assign pend      = pend_r;
    assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_prio_encoder.sv
// tb_prio_encoder: scoreboard bench for prio_encoder (N=4).
// The driver applies stimulus on the falling edge and advances a behavioural
// model of the pending set; each new grant the model makes is queued, and the
// expected post-edge status is queued every cycle. A monitor pops grants at
// each observed handshake and status entries just after each rising edge.
module tb_prio_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset_;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pend;
    logic [7:0]   drop_cnt;
`ifdef PRIO_ENC_MASK_EN
    logic [N-1:0] mask;
`endif

    always #5 clk = ~clk;

    prio_encoder #(.N(N)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req),
`ifdef PRIO_ENC_MASK_EN
        .mask      (mask),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pend      (pend),
        .drop_cnt  (drop_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: pending set as individual flags plus the held grant.
    bit m_pend[N];
    bit m_mask[N];
    bit m_valid;
    int m_idx;
    int m_drop;

    typedef struct {
        int pend;
        int drop;
        int valid;
        int idx;
    } status_t;

    status_t status_q[$];
    int      grant_q[$];
    status_t st;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pend_word();
        int w = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) w += (1 << i);
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_drop  = 0;
        grant_q.delete();
        status_q.delete();
    endtask

    // One clock of stimulus; the model predicts the state after the next rising edge.
    task automatic cycle(input logic [N-1:0] r, input logic rdy);
        int  acc;
        bit  lost;
        int  best;
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        acc  = (m_valid && rdy) ? m_idx : -1;
        lost = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && m_pend[i] && (i != acc)) lost = 1'b1;
        end
        if (lost && (m_drop < 255)) m_drop++;
        if (acc >= 0) m_pend[acc] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) m_pend[i] = 1'b1;
        end
        if (!m_valid || (acc >= 0)) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (best < 0 && m_pend[i] && !m_mask[i]) best = i;
            end
            if (best >= 0) begin
                m_valid = 1'b1;
                m_idx   = best;
                grant_q.push_back(best);
            end else begin
                m_valid = 1'b0;
            end
        end
        status_q.push_back('{pend_word(), m_drop, int'(m_valid), m_idx});
    endtask

    // Wait until just after the next rising edge, past the monitor's sample point.
    task automatic post();
        @(posedge clk);
        #3;
    endtask

`ifdef PRIO_ENC_MASK_EN
    task automatic set_mask(input logic [N-1:0] m);
        mask = m;
        for (int i = 0; i < N; i++) m_mask[i] = m[i];
    endtask
`endif

    // Monitor: consume a grant on each handshake, then check the post-edge status.
    always @(posedge clk) begin
        if (reset_ && out_valid && out_ready) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_grant", int'(out_idx), -1);
            end else begin
                chk("grant_idx", int'(out_idx), grant_q.pop_front());
            end
        end
        #1;
        if (status_q.size() > 0) begin
            st = status_q.pop_front();
            chk("pend", int'(pend), st.pend);
            chk("drop_cnt", int'(drop_cnt), st.drop);
            chk("out_valid", int'(out_valid), st.valid);
            if (st.valid != 0) chk("held_idx", int'(out_idx), st.idx);
        end
    end

    task automatic async_reset();
        post();
        chk("pre_reset_hold", int'(out_valid), 1);
        reset_    = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_idx", int'(out_idx), 0);
        chk("arst_pend", int'(pend), 0);
        chk("arst_drop", int'(drop_cnt), 0);
        req       = '0;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic drain();
        repeat (N + 2) cycle('0, 1'b1);
        post();
        chk("grants_left", grant_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
        model_clear();
        reset_    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
`ifdef PRIO_ENC_MASK_EN
        mask      = '0;
`endif
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;

        // Single request: one-cycle latency, then acceptance clears it.
        cycle(4'b0100, 1'b0);
        post();
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_idx", int'(out_idx), 2);
        chk("t1_pend", int'(pend), 4);
        cycle(4'b0000, 1'b1);
        post();
        chk("t1_acc_valid", int'(out_valid), 0);
        chk("t1_acc_pend", int'(pend), 0);

        // Two lines at once with ready held: back-to-back grants 1 then 3.
        cycle(4'b1010, 1'b1);
        post();
        chk("t2_first", int'(out_idx), 1);
        cycle(4'b0000, 1'b1);
        post();
        chk("t2_second_valid", int'(out_valid), 1);
        chk("t2_second", int'(out_idx), 3);
        cycle(4'b0000, 1'b1);
        post();
        chk("t2_idle", int'(out_valid), 0);

        // No pre-emption: held 3 stays until accepted, then 0 follows.
        cycle(4'b1000, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        post();
        chk("t3_held", int'(out_idx), 3);
        cycle(4'b0000, 1'b1);
        post();
        chk("t3_next", int'(out_idx), 0);
        cycle(4'b0000, 1'b1);

        // Three collisions on a pending, ungranted line.
        cycle(4'b0101, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        post();
        chk("t4_drop3", int'(drop_cnt), 3);
        drain();

        // Accept idx 1 while req[1] fires again: re-granted, no drop.
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b1);
        post();
        chk("t5_pend1", int'(pend[1]), 1);
        chk("t5_regrant", int'(out_idx), 1);
        chk("t5_drop", int'(drop_cnt), 3);
        drain();

`ifdef PRIO_ENC_MASK_EN
        // Masked line pends but is never selected.
        set_mask(4'b0001);
        cycle(4'b0011, 1'b1);
        post();
        chk("m_grant", int'(out_idx), 1);
        cycle(4'b0000, 1'b1);
        post();
        chk("m_idle", int'(out_valid), 0);
        chk("m_pend0", int'(pend), 1);
        set_mask(4'b0000);
        drain();
`endif

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
`ifdef PRIO_ENC_MASK_EN
            if ($urandom_range(0, 15) == 0) set_mask(N'($urandom));
`endif
            cycle(($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0),
                  ($urandom_range(0, 3) != 0));
        end
`ifdef PRIO_ENC_MASK_EN
        set_mask(4'b0000);
`endif
        drain();

        // Long collision: drop counter saturates.
        repeat (300) cycle(4'b0100, 1'b0);
        post();
        chk("sat_drop", int'(drop_cnt), 255);

        // Asynchronous reset while holding a grant.
        async_reset();
        for (int k = 0; k < 60; k++) begin
            cycle(($urandom_range(0, 1) == 0) ? N'($urandom) : N'(0),
                  ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
